// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI receive parser: parser states,
// special status bytes and the data-length lookup for a status byte.
package midi_pkg;

  typedef enum logic [1:0] {
    NOSTAT = 2'd0,
    CHAN   = 2'd1,
    SYSCOM = 2'd2,
    SYSEX  = 2'd3
  } parser_state_t;

  localparam logic [7:0] ST_SYSEX = 8'hF0;
  localparam logic [7:0] ST_EOX   = 8'hF7;
  localparam logic [7:0] RT_SENSE = 8'hFE;
  localparam logic [7:0] RT_RESET = 8'hFF;

  // Number of data bytes that follow a status byte. F4/F5 are undefined and
  // behave like F6. SysEx (F0) has an open length and is not looked up here.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF: begin
        case (status[3:0])
          4'h1, 4'h3: len = 2'd1;
          4'h2:       len = 2'd2;
          default:    len = 2'd0;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_rx_parser_if.sv
// Byte stream from the UART receiver into the parser and the parsed stream out.
// rx_valid is a one-cycle strobe with no back-pressure; every output strobe is
// also a single cycle and carries no ready, so the consumer must take it then.
interface midi_rx_parser_if;
  import midi_pkg::*;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_frame_err;

  logic          byteready;
  logic [7:0]    cur_status;
  logic [7:0]    midibyte_nr;
  logic [7:0]    midi_in_data;
  logic          sysex_end;
  logic          rt_valid;
  logic [7:0]    rt_data;
  logic          sense_timeout;
  logic          err_orphan;
  parser_state_t state_dbg;

  modport master (
    output rx_valid, rx_data, rx_frame_err,
    input  byteready, cur_status, midibyte_nr, midi_in_data, sysex_end,
           rt_valid, rt_data, sense_timeout, err_orphan, state_dbg
  );

  modport slave (
    input  rx_valid, rx_data, rx_frame_err,
    output byteready, cur_status, midibyte_nr, midi_in_data, sysex_end,
           rt_valid, rt_data, sense_timeout, err_orphan, state_dbg
  );

endinterface

// File: rtl/midi_sense_timer.sv
// Active Sensing supervisor: once armed, counts idle cycles and flags expiry.
// timeout is combinational for the one cycle in which the silence limit is hit.
module midi_sense_timer #(
  parameter int unsigned SENSE_TIMEOUT = 7500000,
  parameter int unsigned SENSE_W       = 23
) (
  input  logic CLOCK_25,
  input  logic reset_reg_N,
  input  logic arm,
  input  logic disarm,
  input  logic kick,
  output logic timeout
);

  localparam logic [SENSE_W-1:0] LAST = SENSE_W'(SENSE_TIMEOUT - 1);

  logic               armed;
  logic [SENSE_W-1:0] cnt;

  // A received byte in the expiry cycle wins over the timeout.
  assign timeout = armed && !kick && (cnt == LAST);

  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (disarm) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (arm) begin
      armed <= 1'b1;
      cnt   <= '0;
    end else if (timeout) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (armed) begin
      cnt <= kick ? '0 : cnt + SENSE_W'(1);
    end
  end

endmodule

// File: rtl/midi_rx_parser.sv
// MIDI byte-stream parser: running status, message length tracking, SysEx
// framing, real-time pass-through and Active Sensing timeout.
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int unsigned SENSE_TIMEOUT = 7500000,
  parameter int unsigned SENSE_W       = 23
) (
  input logic              CLOCK_25,
  input logic              reset_reg_N,
  midi_rx_parser_if.slave  bus
);

  parser_state_t state, state_n;
  logic [7:0]    cur_status, cur_status_n;
  logic [7:0]    nr, nr_n;
  logic [7:0]    in_data, in_data_n;
  logic [7:0]    rt_data, rt_data_n;
  logic          byteready, byteready_n;
  logic          sysex_end, sysex_end_n;
  logic          rt_valid, rt_valid_n;
  logic          sense_timeout, sense_timeout_n;
  logic          err_orphan, err_orphan_n;

  logic       good, is_rt, is_status, is_data;
  logic       arm, disarm, expire;
  logic [7:0] exp_len;
  logic [7:0] nr_sat;

  assign good      = bus.rx_valid && !bus.rx_frame_err;
  assign is_rt     = good && (bus.rx_data >= 8'hF8);
  assign is_status = good && bus.rx_data[7] && !is_rt;
  assign is_data   = good && !bus.rx_data[7];
  assign arm       = is_rt && (bus.rx_data == RT_SENSE);
  assign disarm    = is_rt && (bus.rx_data == RT_RESET);
  assign exp_len   = {6'd0, msg_len(cur_status)};
  assign nr_sat    = (nr == 8'hFF) ? nr : nr + 8'd1;

  midi_sense_timer #(
    .SENSE_TIMEOUT (SENSE_TIMEOUT),
    .SENSE_W       (SENSE_W)
  ) u_sense (
    .CLOCK_25    (CLOCK_25),
    .reset_reg_N (reset_reg_N),
    .arm         (arm),
    .disarm      (disarm),
    .kick        (bus.rx_valid),
    .timeout     (expire)
  );

  always_comb begin
    state_n         = state;
    cur_status_n    = cur_status;
    nr_n            = nr;
    in_data_n       = in_data;
    rt_data_n       = rt_data;
    byteready_n     = 1'b0;
    sysex_end_n     = 1'b0;
    rt_valid_n      = 1'b0;
    sense_timeout_n = 1'b0;
    err_orphan_n    = 1'b0;

    // F0 is held for one cycle after F7 closes a SysEx; NOSTAT drops it here.
    if (state == NOSTAT) cur_status_n = 8'h00;

    if (bus.rx_valid && bus.rx_frame_err) begin
      err_orphan_n = 1'b1;
    end else if (is_rt) begin
      rt_valid_n = 1'b1;
      rt_data_n  = bus.rx_data;
      if (disarm) begin
        state_n      = NOSTAT;
        cur_status_n = 8'h00;
      end
    end else if (is_status) begin
      if (bus.rx_data == ST_EOX) begin
        if (state == SYSEX) begin
          byteready_n = 1'b1;
          sysex_end_n = 1'b1;
          in_data_n   = bus.rx_data;
          nr_n        = nr_sat;
          state_n     = NOSTAT;
        end
      end else begin
        byteready_n  = 1'b1;
        cur_status_n = bus.rx_data;
        in_data_n    = bus.rx_data;
        nr_n         = 8'd0;
        if (bus.rx_data[7:4] != 4'hF)     state_n = CHAN;
        else if (bus.rx_data == ST_SYSEX) state_n = SYSEX;
        else                              state_n = SYSCOM;
      end
    end else if (is_data) begin
      case (state)
        CHAN: begin
          byteready_n = 1'b1;
          in_data_n   = bus.rx_data;
          nr_n        = (nr >= exp_len) ? 8'd1 : nr + 8'd1;
        end
        SYSCOM: begin
          if (nr >= exp_len) begin
            err_orphan_n = 1'b1;
            state_n      = NOSTAT;
          end else begin
            byteready_n = 1'b1;
            in_data_n   = bus.rx_data;
            nr_n        = nr + 8'd1;
          end
        end
        SYSEX: begin
          byteready_n = 1'b1;
          in_data_n   = bus.rx_data;
          nr_n        = nr_sat;
        end
        default: err_orphan_n = 1'b1;
      endcase
    end else if (expire) begin
      sense_timeout_n = 1'b1;
      state_n         = NOSTAT;
      cur_status_n    = 8'h00;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state         <= NOSTAT;
      cur_status    <= 8'h00;
      nr            <= 8'h00;
      in_data       <= 8'h00;
      rt_data       <= 8'h00;
      byteready     <= 1'b0;
      sysex_end     <= 1'b0;
      rt_valid      <= 1'b0;
      sense_timeout <= 1'b0;
      err_orphan    <= 1'b0;
    end else begin
      state         <= state_n;
      cur_status    <= cur_status_n;
      nr            <= nr_n;
      in_data       <= in_data_n;
      rt_data       <= rt_data_n;
      byteready     <= byteready_n;
      sysex_end     <= sysex_end_n;
      rt_valid      <= rt_valid_n;
      sense_timeout <= sense_timeout_n;
      err_orphan    <= err_orphan_n;
    end
  end

  assign bus.byteready     = byteready;
  assign bus.cur_status    = cur_status;
  assign bus.midibyte_nr   = nr;
  assign bus.midi_in_data  = in_data;
  assign bus.sysex_end     = sysex_end;
  assign bus.rt_valid      = rt_valid;
  assign bus.rt_data       = rt_data;
  assign bus.sense_timeout = sense_timeout;
  assign bus.err_orphan    = err_orphan;
  assign bus.state_dbg     = state;

endmodule
